// File: rtl/phase_timer.sv
// phase_timer: four-phase traffic sequencer (GREEN -> YELLOW -> ALL_RED) for
// an 8-lane intersection, with safe emergency preemption (EMERG state).
// Optional build macro: PHASE_TIMER_FAST_PREEMPT_EN -- when defined, a GREEN
// request whose mask covers every currently lit lane jumps straight to EMERG
// without a yellow/all-red gap.
// Handshake: none. loadCommand is a level that is sampled every cycle; there
// is no ready/acknowledge, and the last request seen overwrites the pending one.
// The FSM state is held in the register `state` (type phaseState_t).
module phase_timer #(
  parameter int GREEN_TIME  = 20,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 1,
  parameter int TIME_W      = 7
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              tickEn,
  input  logic [0:7]        laneOutput,
  input  logic              loadCommand,
  input  logic [TIME_W-1:0] loadTime,
  output logic [0:7]        greenLanes,
  output logic [0:7]        yellowLanes,
  output logic [TIME_W-1:0] timeRemaining,
  output logic [1:0]        phase,
  output logic              emergencyActive
);

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    EMERG   = 2'd3
  } phaseState_t;

  localparam logic [TIME_W-1:0] ONE       = TIME_W'(1);
  // A zero duration is stretched to one tick so every state lasts >= 1 tick.
  localparam logic [TIME_W-1:0] GREEN_LD  = (GREEN_TIME  == 0) ? ONE : TIME_W'(GREEN_TIME);
  localparam logic [TIME_W-1:0] YELLOW_LD = (YELLOW_TIME == 0) ? ONE : TIME_W'(YELLOW_TIME);
  localparam logic [TIME_W-1:0] ALLRED_LD = (ALLRED_TIME == 0) ? ONE : TIME_W'(ALLRED_TIME);

  phaseState_t       state, stateNext;
  logic [1:0]        phaseNext;
  logic [TIME_W-1:0] counter, counterNext;
  logic              pend, pendNext;
  logic [0:7]        pendMask, pendMaskNext;
  logic [TIME_W-1:0] pendTime, pendTimeNext;
  logic [0:7]        curMask, curMaskNext;
  logic              req, expire, fastOk;

  function automatic logic [TIME_W-1:0] clampDur(input logic [TIME_W-1:0] d);
    return (d == '0) ? ONE : d;
  endfunction

  // Two adjacent lanes served by a normal phase; lane 0 is the leftmost bit.
  function automatic logic [0:7] phaseLanes(input logic [1:0] p);
    logic [0:7] m;
    m = 8'b1100_0000 >> {p, 1'b0};
    return m;
  endfunction

  assign req    = loadCommand && (laneOutput != '0);
  assign expire = tickEn && (counter == ONE);

`ifdef PHASE_TIMER_FAST_PREEMPT_EN
  assign fastOk = ((laneOutput & curMask) == curMask);
`else
  assign fastOk = 1'b0;
`endif

  // Next-state, countdown and request-capture logic.
  always_comb begin
    stateNext    = state;
    phaseNext    = phase;
    counterNext  = counter;
    pendNext     = pend;
    pendMaskNext = pendMask;
    pendTimeNext = pendTime;
    curMaskNext  = curMask;

    if (req) begin
      pendNext     = 1'b1;
      pendMaskNext = laneOutput;
      pendTimeNext = loadTime;
    end
    if (tickEn) counterNext = counter - ONE;

    case (state)
      GREEN: begin
        if (req && fastOk) begin
          stateNext   = EMERG;
          curMaskNext = laneOutput;
          counterNext = clampDur(loadTime);
          pendNext    = 1'b0;
        end else if (req || expire) begin
          stateNext   = YELLOW;
          counterNext = YELLOW_LD;
        end
      end
      YELLOW: begin
        if (expire) begin
          stateNext   = ALL_RED;
          counterNext = ALLRED_LD;
        end
      end
      ALL_RED: begin
        if (expire) begin
          if (req || pend) begin
            // A request on this very cycle is the newest, so it wins.
            stateNext   = EMERG;
            curMaskNext = req ? laneOutput : pendMask;
            counterNext = clampDur(req ? loadTime : pendTime);
            pendNext    = 1'b0;
          end else begin
            // phase always names the next phase to serve, so it advances as
            // soon as a phase is taken; a preempted phase is thereby skipped.
            stateNext   = GREEN;
            curMaskNext = phaseLanes(phase);
            phaseNext   = phase + 2'd1;
            counterNext = GREEN_LD;
          end
        end
      end
      EMERG: begin
        if (req && (laneOutput == curMask)) begin
          // Refresh of the running emergency: extend, do not queue.
          counterNext  = clampDur(loadTime);
          pendNext     = pend;
          pendMaskNext = pendMask;
          pendTimeNext = pendTime;
        end else if (req || expire) begin
          stateNext   = YELLOW;
          counterNext = YELLOW_LD;
        end
      end
      default: stateNext = ALL_RED;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state    <= ALL_RED;
      phase    <= 2'd0;
      counter  <= ALLRED_LD;
      pend     <= 1'b0;
      pendMask <= '0;
      pendTime <= '0;
      curMask  <= '0;
    end else begin
      state    <= stateNext;
      phase    <= phaseNext;
      counter  <= counterNext;
      pend     <= pendNext;
      pendMask <= pendMaskNext;
      pendTime <= pendTimeNext;
      curMask  <= curMaskNext;
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    greenLanes      = '0;
    yellowLanes     = '0;
    emergencyActive = 1'b0;
    case (state)
      GREEN:   greenLanes = curMask;
      EMERG: begin
        greenLanes      = curMask;
        emergencyActive = 1'b1;
      end
      YELLOW:  yellowLanes = curMask;
      default: ;
    endcase
  end

  assign timeRemaining = counter;

endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: table-driven bench for phase_timer (default parameters),
// plus hand-written sequences for stall, reset, expiry-edge requests and the
// PHASE_TIMER_FAST_PREEMPT_EN build option.
module tb_phase_timer;

  localparam logic [0:7] NONE  = 8'b0000_0000;
  localparam logic [0:7] M01   = 8'b1100_0000;
  localparam logic [0:7] M23   = 8'b0011_0000;
  localparam logic [0:7] M45   = 8'b0000_1100;
  localparam logic [0:7] M67   = 8'b0000_0011;
  localparam logic [0:7] M0123 = 8'b1111_0000;

  logic       clk;
  logic       resetN;
  logic       tickEn;
  logic [0:7] laneOutput;
  logic       loadCommand;
  logic [6:0] loadTime;
  logic [0:7] greenLanes;
  logic [0:7] yellowLanes;
  logic [6:0] timeRemaining;
  logic [1:0] phase;
  logic       emergencyActive;

  int checks   = 0;
  int failures = 0;

  phase_timer dut (
    .clk(clk),
    .resetN(resetN),
    .tickEn(tickEn),
    .laneOutput(laneOutput),
    .loadCommand(loadCommand),
    .loadTime(loadTime),
    .greenLanes(greenLanes),
    .yellowLanes(yellowLanes),
    .timeRemaining(timeRemaining),
    .phase(phase),
    .emergencyActive(emergencyActive)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table row: inputs held for n cycles, expected outputs after each edge.
  // When dec is set the expected time counts down by one per cycle from t.
  typedef struct {
    logic       rstN;
    logic       tick;
    logic       lc;
    logic [0:7] mask;
    logic [6:0] ltime;
    int         n;
    logic [0:7] g;
    logic [0:7] y;
    logic [6:0] t;
    logic       dec;
    logic [1:0] ph;
    logic       e;
  } vec_t;

  vec_t vecs[$];

  task automatic addRow(input logic rstN, tick, lc, input logic [0:7] mask,
                        input logic [6:0] ltime, input int n,
                        input logic [0:7] g, y, input logic [6:0] t,
                        input logic dec, input logic [1:0] ph, input logic e);
    vec_t v;
    v.rstN = rstN; v.tick = tick; v.lc = lc; v.mask = mask; v.ltime = ltime;
    v.n = n; v.g = g; v.y = y; v.t = t; v.dec = dec; v.ph = ph; v.e = e;
    vecs.push_back(v);
  endtask

  // Driver tasks
  task automatic drive(input logic rstN, tick, lc, input logic [0:7] mask,
                       input logic [6:0] ltime);
    resetN      = rstN;
    tickEn      = tick;
    loadCommand = lc;
    laneOutput  = mask;
    loadTime    = ltime;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic chk(input string tag, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0h required=%0h", tag, field, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [0:7] g, y,
                          input logic [6:0] t, input logic [1:0] ph, input logic e);
    chk(tag, "green",  32'(greenLanes),  32'(g));
    chk(tag, "yellow", 32'(yellowLanes), 32'(y));
    chk(tag, "time",   32'(timeRemaining), 32'(t));
    chk(tag, "phase",  32'(phase), 32'(ph));
    chk(tag, "emerg",  32'(emergencyActive), 32'(e));
    chk(tag, "overlap", 32'(greenLanes & yellowLanes), 32'd0);
  endtask

  initial begin
    drive(1'b0, 1'b1, 1'b0, NONE, 7'd0);

    // Scenario 1: reset and normal rotation
    addRow(0,1,0,NONE,0, 2, NONE,NONE,1, 0,0,0);
    addRow(1,1,0,NONE,0,20, M01, NONE,20,1,1,0);
    addRow(1,1,0,NONE,0, 3, NONE,M01, 3, 1,1,0);
    addRow(1,1,0,NONE,0, 1, NONE,NONE,1, 0,1,0);
    addRow(1,1,0,NONE,0,20, M23, NONE,20,1,2,0);
    addRow(1,1,0,NONE,0, 3, NONE,M23, 3, 1,2,0);
    addRow(1,1,0,NONE,0, 1, NONE,NONE,1, 0,2,0);
    addRow(1,1,0,NONE,0, 1, M45, NONE,20,0,3,0);
    // Scenario 2: preemption in phase-0 green
    addRow(0,1,0,NONE,0, 1, NONE,NONE,1, 0,0,0);
    addRow(1,1,0,NONE,0, 5, M01, NONE,20,1,1,0);
    addRow(1,1,1,M45, 4, 1, NONE,M01, 3, 0,1,0);
    addRow(1,1,0,NONE,0, 2, NONE,M01, 2, 1,1,0);
    addRow(1,1,0,NONE,0, 1, NONE,NONE,1, 0,1,0);
    addRow(1,1,0,NONE,0, 4, M45, NONE,4, 1,1,1);
    addRow(1,1,0,NONE,0, 3, NONE,M45, 3, 1,1,0);
    addRow(1,1,0,NONE,0, 1, NONE,NONE,1, 0,1,0);
    addRow(1,1,0,NONE,0, 1, M23, NONE,20,0,2,0);
    // Scenario 3: held same-mask request refreshes EMERG
    addRow(0,1,0,NONE,0, 1, NONE,NONE,1, 0,0,0);
    addRow(1,1,0,NONE,0, 3, M01, NONE,20,1,1,0);
    addRow(1,1,1,M45, 4, 1, NONE,M01, 3, 0,1,0);
    addRow(1,1,1,M45, 4, 2, NONE,M01, 2, 1,1,0);
    addRow(1,1,1,M45, 4, 1, NONE,NONE,1, 0,1,0);
    addRow(1,1,1,M45, 4, 1, M45, NONE,4, 0,1,1);
    addRow(1,1,1,M45, 4, 6, M45, NONE,4, 0,1,1);
    addRow(1,1,0,NONE,0, 3, M45, NONE,3, 1,1,1);
    addRow(1,1,0,NONE,0, 3, NONE,M45, 3, 1,1,0);
    addRow(1,1,0,NONE,0, 1, NONE,NONE,1, 0,1,0);
    addRow(1,1,0,NONE,0, 1, M23, NONE,20,0,2,0);
    // Scenario 4: mask change during EMERG
    addRow(0,1,0,NONE,0, 1, NONE,NONE,1, 0,0,0);
    addRow(1,1,0,NONE,0, 2, M01, NONE,20,1,1,0);
    addRow(1,1,1,M45, 5, 1, NONE,M01, 3, 0,1,0);
    addRow(1,1,0,NONE,0, 2, NONE,M01, 2, 1,1,0);
    addRow(1,1,0,NONE,0, 1, NONE,NONE,1, 0,1,0);
    addRow(1,1,0,NONE,0, 2, M45, NONE,5, 1,1,1);
    addRow(1,1,1,M67, 2, 1, NONE,M45, 3, 0,1,0);
    addRow(1,1,0,NONE,0, 2, NONE,M45, 2, 1,1,0);
    addRow(1,1,0,NONE,0, 1, NONE,NONE,1, 0,1,0);
    addRow(1,1,0,NONE,0, 2, M67, NONE,2, 1,1,1);
    addRow(1,1,0,NONE,0, 3, NONE,M67, 3, 1,1,0);
    addRow(1,1,0,NONE,0, 1, NONE,NONE,1, 0,1,0);
    addRow(1,1,0,NONE,0, 1, M23, NONE,20,0,2,0);

    foreach (vecs[r]) begin
      for (int k = 0; k < vecs[r].n; k++) begin
        drive(vecs[r].rstN, vecs[r].tick, vecs[r].lc, vecs[r].mask, vecs[r].ltime);
        step();
        checkAll($sformatf("row%0d_c%0d", r, k), vecs[r].g, vecs[r].y,
                 vecs[r].dec ? 7'(vecs[r].t - 7'(k)) : vecs[r].t,
                 vecs[r].ph, vecs[r].e);
      end
    end

    // Stall: zero-mask ignored, tick held low, request captured while stalled
    drive(0,1,0,NONE,0);  step(); checkAll("st_rst", NONE,NONE,1,0,0);
    drive(1,1,0,NONE,0);  step(); checkAll("st_g",   M01,NONE,20,1,0);
    drive(1,1,1,NONE,9);  step(); checkAll("st_zero",M01,NONE,19,1,0);
    drive(1,1,1,M45,4);   step(); checkAll("st_pre", NONE,M01,3,1,0);
    for (int i = 0; i < 50; i++) begin
      drive(1,0,(i == 25),(i == 25) ? M67 : NONE, 7'd6);
      step();
      checkAll($sformatf("stall%0d", i), NONE,M01,3,1,0);
    end
    drive(1,1,0,NONE,0);
    step(); checkAll("st_y2", NONE,M01,2,1,0);
    step(); checkAll("st_y1", NONE,M01,1,1,0);
    step(); checkAll("st_ar", NONE,NONE,1,1,0);
    step(); checkAll("st_em", M67,NONE,6,1,1);
    step(); checkAll("st_em5",M67,NONE,5,1,1);
    // Reset mid-EMERG
    drive(0,1,0,NONE,0);  step(); checkAll("st_rst2",NONE,NONE,1,0,0);
    drive(1,1,0,NONE,0);  step(); checkAll("st_res", M01,NONE,20,1,0);

    // Reset discards a pending request
    drive(1,1,1,M23,3);   step(); checkAll("pd_y",   NONE,M01,3,1,0);
    drive(0,1,0,NONE,0);  step(); checkAll("pd_rst", NONE,NONE,1,0,0);
    drive(1,1,0,NONE,0);  step(); checkAll("pd_g",   M01,NONE,20,1,0);

    // Request on the GREEN expiry cycle
    for (int i = 0; i < 19; i++) step();
    checkAll("ge_last", M01,NONE,1,1,0);
    drive(1,1,1,M45,2);   step(); checkAll("ge_y",  NONE,M01,3,1,0);
    drive(1,1,0,NONE,0);
    step(); step();       checkAll("ge_y1", NONE,M01,1,1,0);
    step();               checkAll("ge_ar", NONE,NONE,1,1,0);
    step();               checkAll("ge_em", M45,NONE,2,1,1);
    step(); step();       checkAll("ge_ex", NONE,M45,3,1,0);

    // Request on the ALL_RED expiry cycle, with zero duration
    drive(0,1,0,NONE,0);  step(); checkAll("ar_rst", NONE,NONE,1,0,0);
    drive(1,1,1,M67,0);   step(); checkAll("ar_em",  M67,NONE,1,0,1);
    drive(1,1,0,NONE,0);  step(); checkAll("ar_y",   NONE,M67,3,0,0);
    step(); step(); step(); checkAll("ar_ar",  NONE,NONE,1,0,0);
    step();               checkAll("ar_g",   M01,NONE,20,1,0);

    // Superset request in phase-0 green
    drive(0,1,0,NONE,0);  step(); checkAll("fp_rst", NONE,NONE,1,0,0);
    drive(1,1,0,NONE,0);  step(); checkAll("fp_g",   M01,NONE,20,1,0);
    drive(1,1,1,M0123,4); step();
`ifdef PHASE_TIMER_FAST_PREEMPT_EN
    checkAll("fp_em", M0123,NONE,4,1,1);
`else
    checkAll("fp_y",  NONE,M01,3,1,0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
